// File: rtl/bvh_table_loader_pkg.sv
// Shared definitions for the BVH table loader.
// Holds record geometry (raw record widths, byte counts, index width) and the
// loader state encoding used by the top-level FSM.
package bvh_table_loader_pkg;

    localparam int BVH_NODE_RAW_DATA_WIDTH = 224;
    localparam int BVH_LEAF_RAW_DATA_WIDTH = 232;
    localparam int BVH_NODE_INDEX_WIDTH    = 16;

    localparam logic [4:0] NODE_RECORD_BYTES = 5'd28;
    localparam logic [4:0] LEAF_RECORD_BYTES = 5'd29;
    localparam logic [4:0] HEADER_BYTES      = 5'd4;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        NODES,
        LEAVES,
        DONE,
        ERROR
    } BVHLoaderState;

endpackage

// File: rtl/_BVHRecordAssembler.sv
// Byte-to-record assembler for the BVH table loader.
// Shifts accepted bytes in big-endian order and counts them; rec_done flags
// the cycle in which the final byte of a record (rec_len bytes) is accepted,
// with rec_data presenting the complete record in that same cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           drop any partial record (start of a new load)
//   byte_valid      byte_in is accepted this cycle
//   byte_in         stream byte
//   rec_len         bytes per record for the current phase
//   byte_cnt        bytes already held for the current record
//   last_byte       most recently accepted byte of the current record
//   rec_data        held bytes with byte_in appended as the least significant byte
//   rec_done        byte_in completes the record this cycle
module _BVHRecordAssembler
    import bvh_table_loader_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               byte_valid,
    input  logic [7:0]                         byte_in,
    input  logic [4:0]                         rec_len,
    output logic [4:0]                         byte_cnt,
    output logic [7:0]                         last_byte,
    output logic [BVH_LEAF_RAW_DATA_WIDTH-1:0] rec_data,
    output logic                               rec_done
);

    logic [BVH_LEAF_RAW_DATA_WIDTH-9:0] shift_q, shift_d;
    logic [4:0]                         cnt_q, cnt_d;

    assign rec_data  = {shift_q, byte_in};
    assign rec_done  = byte_valid && (cnt_q == rec_len - 5'd1);
    assign byte_cnt  = cnt_q;
    assign last_byte = shift_q[7:0];

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (rec_done) begin
            // Start the next record from zero so short (node) records leave
            // the unused top byte clear.
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = rec_data[BVH_LEAF_RAW_DATA_WIDTH-9:0];
            cnt_d   = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/bvh_table_loader.sv
// BVH table loader: parses a byte stream (4-byte header, then node records,
// then leaf records) and issues one table write per completed record.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a load (honoured in IDLE, DONE, ERROR)
//   in_valid/in_byte/in_ready  byte stream handshake
//   wr_valid/wr_ready          table write handshake
//   wr_is_leaf/wr_addr/wr_data write target table, index and record
//   init_done                  load complete
//   error                      header counts exceed table depths
//   node_count/leaf_count      counts latched from the header
module bvh_table_loader
    import bvh_table_loader_pkg::*;
#(
    parameter int NODE_DEPTH = 1024,
    parameter int LEAF_DEPTH = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    output logic         in_ready,
    output logic         wr_valid,
    input  logic         wr_ready,
    output logic         wr_is_leaf,
    output logic [15:0]  wr_addr,
    output logic [231:0] wr_data,
    output logic         init_done,
    output logic         error,
    output logic [15:0]  node_count,
    output logic [15:0]  leaf_count
);

    localparam logic [16:0] NODE_LIMIT = 17'(NODE_DEPTH);
    localparam logic [16:0] LEAF_LIMIT = 17'(LEAF_DEPTH);

    BVHLoaderState                        state_q, state_d;
    logic                                 wr_valid_q, wr_valid_d;
    logic                                 wr_is_leaf_q, wr_is_leaf_d;
    logic [BVH_NODE_INDEX_WIDTH-1:0]      wr_addr_q, wr_addr_d;
    logic [BVH_LEAF_RAW_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [15:0]                          node_count_q, node_count_d;
    logic [15:0]                          leaf_count_q, leaf_count_d;

    logic                                 in_stream, take, asm_valid, asm_clear;
    logic                                 rec_done, last_write;
    logic [4:0]                           rec_len, byte_cnt;
    logic [7:0]                           last_byte;
    logic [15:0]                          hdr_leaf_count;
    logic [BVH_LEAF_RAW_DATA_WIDTH-1:0]   rec_data;

    // Stream phases stall while a write is pending so no byte is lost;
    // ERROR keeps draining the stream without assembling anything.
    assign in_stream = (state_q == HEADER) || (state_q == NODES) || (state_q == LEAVES);
    assign in_ready  = (in_stream && !wr_valid_q) || (state_q == ERROR);
    assign take      = in_valid && in_ready;
    assign asm_valid = take && in_stream;

    assign hdr_leaf_count = {last_byte, in_byte};
    assign last_write = (state_q == NODES) ? (wr_addr_q == node_count_q - 16'd1)
                                           : (wr_addr_q == leaf_count_q - 16'd1);

    always_comb begin
        case (state_q)
            HEADER:  rec_len = HEADER_BYTES;
            NODES:   rec_len = NODE_RECORD_BYTES;
            default: rec_len = LEAF_RECORD_BYTES;
        endcase
    end

    _BVHRecordAssembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (in_byte),
        .rec_len    (rec_len),
        .byte_cnt   (byte_cnt),
        .last_byte  (last_byte),
        .rec_data   (rec_data),
        .rec_done   (rec_done)
    );

    always_comb begin
        state_d      = state_q;
        wr_valid_d   = wr_valid_q;
        wr_is_leaf_d = wr_is_leaf_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        node_count_d = node_count_q;
        leaf_count_d = leaf_count_q;
        asm_clear    = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d   = HEADER;
                    wr_addr_d = '0;
                    asm_clear = 1'b1;
                end
            end
            HEADER: begin
                if (take && byte_cnt == 5'd1) begin
                    node_count_d = {last_byte, in_byte};
                end
                if (rec_done) begin
                    // node_count was latched two bytes earlier; leaf count is
                    // taken straight from the stream so the decision needs no
                    // extra cycle.
                    leaf_count_d = hdr_leaf_count;
                    if ({1'b0, node_count_q} > NODE_LIMIT || {1'b0, hdr_leaf_count} > LEAF_LIMIT)
                        state_d = ERROR;
                    else if (node_count_q != 16'd0)
                        state_d = NODES;
                    else if (hdr_leaf_count != 16'd0)
                        state_d = LEAVES;
                    else
                        state_d = DONE;
                end
            end
            NODES, LEAVES: begin
                if (wr_valid_q) begin
                    if (wr_ready) begin
                        wr_valid_d = 1'b0;
                        if (!last_write) begin
                            wr_addr_d = wr_addr_q + 16'd1;
                        end else if (state_q == NODES && leaf_count_q != 16'd0) begin
                            state_d   = LEAVES;
                            wr_addr_d = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end else if (rec_done) begin
                    wr_valid_d   = 1'b1;
                    wr_is_leaf_d = (state_q == LEAVES);
                    wr_data_d    = (state_q == LEAVES) ? rec_data
                                 : {8'h00, rec_data[BVH_NODE_RAW_DATA_WIDTH-1:0]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_valid_q   <= 1'b0;
            wr_is_leaf_q <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            node_count_q <= '0;
            leaf_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_valid_q   <= wr_valid_d;
            wr_is_leaf_q <= wr_is_leaf_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            node_count_q <= node_count_d;
            leaf_count_q <= leaf_count_d;
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_is_leaf = wr_is_leaf_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign node_count = node_count_q;
    assign leaf_count = leaf_count_q;
    assign init_done  = (state_q == DONE);
    assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_bvh_table_loader.sv
// Directed testbench for bvh_table_loader: header parsing, node/leaf writes,
// write backpressure, empty load, oversize header, mid-record reset and
// start-pulse handling. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_bvh_table_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_byte = 8'h00;
    logic         in_ready;
    logic         wr_valid;
    logic         wr_ready = 1'b1;
    logic         wr_is_leaf;
    logic [15:0]  wr_addr;
    logic [231:0] wr_data;
    logic         init_done;
    logic         error;
    logic [15:0]  node_count;
    logic [15:0]  leaf_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [231:0] wq_data[$];
    logic [15:0]  wq_addr[$];
    logic         wq_leaf[$];

    always #5 clk = ~clk;

    bvh_table_loader #(.NODE_DEPTH(1024), .LEAF_DEPTH(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_is_leaf (wr_is_leaf),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .init_done  (init_done),
        .error      (error),
        .node_count (node_count),
        .leaf_count (leaf_count)
    );

    // Log every write that will complete on the coming rising edge.
    always @(negedge clk) begin
        if (wr_valid && wr_ready && !reset) begin
            wq_data.push_back(wr_data);
            wq_addr.push_back(wr_addr);
            wq_leaf.push_back(wr_is_leaf);
            $display("write #%0d: leaf=%0d addr=%0d data=%h", wq_data.size() - 1, wr_is_leaf, wr_addr, wr_data);
        end
    end

    task automatic chk(input string tag, input logic [231:0] got, input logic [231:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [231:0] mk_rec(input logic [7:0] base, input int n);
        logic [231:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[223:0], 8'(int'(base) + i)};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte and hold it until it has been accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                chk("in_ready_timeout", 232'(in_ready), 232'd1);
                break;
            end
        end
        tick();
    endtask

    task automatic send_rec(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(8'(int'(base) + i));
        in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            if (init_done) break;
            n++;
            if (n > 200) begin
                chk("done_timeout", 232'(init_done), 232'd1);
                break;
            end
        end
        tick();
    endtask

    task automatic check_write(input int idx, input logic leaf, input logic [15:0] addr,
                               input logic [231:0] data);
        if (idx < wq_data.size()) begin
            chk($sformatf("w%0d_leaf", idx), 232'(wq_leaf[idx]), 232'(leaf));
            chk($sformatf("w%0d_addr", idx), 232'(wq_addr[idx]), 232'(addr));
            chk($sformatf("w%0d_data", idx), wq_data[idx], data);
        end else begin
            chk($sformatf("w%0d_present", idx), 232'(wq_data.size()), 232'(idx + 1));
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_in_ready"},   232'(in_ready),   232'd0);
        chk({pfx, "_wr_valid"},   232'(wr_valid),   232'd0);
        chk({pfx, "_wr_is_leaf"}, 232'(wr_is_leaf), 232'd0);
        chk({pfx, "_wr_addr"},    232'(wr_addr),    232'd0);
        chk({pfx, "_wr_data"},    wr_data,          232'd0);
        chk({pfx, "_init_done"},  232'(init_done),  232'd0);
        chk({pfx, "_error"},      232'(error),      232'd0);
        chk({pfx, "_node_count"}, 232'(node_count), 232'd0);
        chk({pfx, "_leaf_count"}, 232'(leaf_count), 232'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_w;
        logic [231:0] exp_node0;
        exp_node0 = 232'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        tick();

        // Single node record, no backpressure
        pulse_start();
        send_header(8'h00, 8'h01, 8'h00, 8'h00);
        chk("t1_node_count", 232'(node_count), 232'd1);
        chk("t1_leaf_count", 232'(leaf_count), 232'd0);
        send_rec(8'h01, 28);
        wait_done();
        chk("t1_nwrites", 232'(wq_data.size()), 232'd1);
        check_write(0, 1'b0, 16'd0, exp_node0);
        chk("t1_init_done", 232'(init_done), 232'd1);
        chk("t1_in_ready", 232'(in_ready), 232'd0);

        // Two nodes + one leaf, first write held off for 5 cycles
        base_w = wq_data.size();
        pulse_start();
        chk("t2_init_done_cleared", 232'(init_done), 232'd0);
        wr_ready = 1'b0;
        send_header(8'h00, 8'h02, 8'h00, 8'h01);
        send_rec(8'h20, 28);
        in_valid = 1'b1;
        in_byte  = 8'h40;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t2_bp%0d_wr_valid", i), 232'(wr_valid), 232'd1);
            chk($sformatf("t2_bp%0d_in_ready", i), 232'(in_ready), 232'd0);
            chk($sformatf("t2_bp%0d_wr_addr", i),  232'(wr_addr),  232'd0);
            chk($sformatf("t2_bp%0d_wr_data", i),  wr_data,        mk_rec(8'h20, 28));
            tick();
        end
        wr_ready = 1'b1;
        send_rec(8'h40, 28);
        send_rec(8'h60, 29);
        wait_done();
        chk("t2_nwrites", 232'(wq_data.size() - base_w), 232'd3);
        check_write(base_w + 0, 1'b0, 16'd0, mk_rec(8'h20, 28));
        check_write(base_w + 1, 1'b0, 16'd1, mk_rec(8'h40, 28));
        check_write(base_w + 2, 1'b1, 16'd0, mk_rec(8'h60, 29));

        // Empty load: DONE straight after the header
        base_w = wq_data.size();
        pulse_start();
        send_header(8'h00, 8'h00, 8'h00, 8'h00);
        chk("t3_init_done", 232'(init_done), 232'd1);
        chk("t3_node_count", 232'(node_count), 232'd0);
        chk("t3_leaf_count", 232'(leaf_count), 232'd0);
        repeat (3) tick();
        chk("t3_nwrites", 232'(wq_data.size() - base_w), 232'd0);

        // Node count 0x0401 exceeds depth 1024
        base_w = wq_data.size();
        pulse_start();
        send_header(8'h04, 8'h01, 8'h00, 8'h00);
        chk("t4_error", 232'(error), 232'd1);
        chk("t4_in_ready", 232'(in_ready), 232'd1);
        chk("t4_node_count", 232'(node_count), 232'h401);
        send_rec(8'h80, 50);
        repeat (3) tick();
        chk("t4_nwrites", 232'(wq_data.size() - base_w), 232'd0);
        chk("t4_error_held", 232'(error), 232'd1);
        pulse_start();
        chk("t4_error_cleared", 232'(error), 232'd0);

        // Reset after 10 bytes of node record 0, then a clean reload
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_start();
        send_header(8'h00, 8'h01, 8'h00, 8'h00);
        send_rec(8'hA0, 10);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        start    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_rst");
        tick();
        base_w = wq_data.size();
        pulse_start();
        send_header(8'h00, 8'h01, 8'h00, 8'h00);
        send_rec(8'hA0, 28);
        wait_done();
        chk("t5_nwrites", 232'(wq_data.size() - base_w), 232'd1);
        check_write(base_w, 1'b0, 16'd0, mk_rec(8'hA0, 28));

        // start during NODES is ignored; start in DONE repeats the load
        for (int pass = 0; pass < 2; pass++) begin
            base_w = wq_data.size();
            pulse_start();
            chk($sformatf("t6_p%0d_init_done", pass), 232'(init_done), 232'd0);
            send_header(8'h00, 8'h02, 8'h00, 8'h00);
            send_rec(8'hC0, 28);
            pulse_start();
            send_rec(8'hE0, 28);
            wait_done();
            chk($sformatf("t6_p%0d_nwrites", pass), 232'(wq_data.size() - base_w), 232'd2);
            check_write(base_w + 0, 1'b0, 16'd0, mk_rec(8'hC0, 28));
            check_write(base_w + 1, 1'b0, 16'd1, mk_rec(8'hE0, 28));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
